// File: rtl/frame_arb_pkg.sv
// Shared types and default bus widths for the frame-buffer SRAM path
// (arbiter, timer and output controller).
package frame_arb_pkg;

   localparam int ADDR_W_DEF = 19;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_WAIT,
      WR,
      TURN
   } arb_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Counts how long the host has been kept waiting for the SRAM and flags
// starvation once the wait reaches STARVE_MAX cycles.
module arb_starve_counter #(
   parameter int STARVE_MAX = 1024
) (
   input  logic clk,
   input  logic n_rst,
   input  logic count_en,
   input  logic clear,
   output logic starved
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] count;

   // Clear wins over counting; the count parks at STARVE_MAX until cleared
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en && (count != CNT_W'(STARVE_MAX))) begin
         count <= count + CNT_W'(1);
      end
   end

   assign starved = (count == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/frame_sram_arbiter.sv
// Arbitrates the single-port frame-buffer SRAM between display reads and
// host writes, driving registered SRAM strobes, address and write data.
module frame_sram_arbiter
   import frame_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int RD_LAT     = 2,
   parameter int WR_CYC     = 2,
   parameter int STARVE_MAX = 1024
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              blank,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_grant,
   output logic              disp_rvalid,
   output logic [DATA_W-1:0] disp_rdata,
   input  logic              host_req,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic              host_starved,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   localparam int PH_W = $clog2(max_int(RD_LAT, WR_CYC) + 1);

   arb_state_t      state;
   logic [PH_W-1:0] phase_cnt;
   logic            host_win;
   logic            starve_en;
   logic            starve_clr;

   // Display normally wins; the host gets through in blanking, when starved,
   // or whenever the display is not asking.
   assign host_win   = host_req & (blank | host_starved | ~disp_req);
   assign starve_en  = host_req & (state != WR) & (state != TURN);
   assign starve_clr = host_ack | ~host_req;

   arb_starve_counter #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .clk     (clk),
      .n_rst   (n_rst),
      .count_en(starve_en),
      .clear   (starve_clr),
      .starved (host_starved)
   );

   // Strobes are registered together with the state so the pins change
   // exactly on the cycle an operation phase begins or ends.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= IDLE;
         phase_cnt   <= '0;
         sram_addr   <= '0;
         sram_wdata  <= '0;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
         disp_rdata  <= '0;
         disp_grant  <= 1'b0;
         disp_rvalid <= 1'b0;
         host_ack    <= 1'b0;
      end else begin
         disp_grant  <= 1'b0;
         disp_rvalid <= 1'b0;
         host_ack    <= 1'b0;
         case (state)
            IDLE: begin
               if (host_win) begin
                  state      <= WR;
                  phase_cnt  <= PH_W'(WR_CYC - 1);
                  sram_addr  <= host_addr;
                  sram_wdata <= host_wdata;
                  sram_ce_n  <= 1'b0;
                  sram_we_n  <= 1'b0;
                  sram_oe_n  <= 1'b1;
               end else if (disp_req) begin
                  state      <= RD;
                  sram_addr  <= disp_addr;
                  sram_ce_n  <= 1'b0;
                  sram_oe_n  <= 1'b0;
                  disp_grant <= 1'b1;
               end
            end
            RD: begin
               state     <= RD_WAIT;
               phase_cnt <= PH_W'(RD_LAT - 1);
            end
            RD_WAIT: begin
               if (phase_cnt == '0) begin
                  state       <= IDLE;
                  disp_rdata  <= sram_rdata;
                  disp_rvalid <= 1'b1;
                  sram_ce_n   <= 1'b1;
                  sram_oe_n   <= 1'b1;
               end else begin
                  phase_cnt <= phase_cnt - PH_W'(1);
               end
            end
            WR: begin
               if (phase_cnt == '0) begin
                  state     <= TURN;
                  sram_ce_n <= 1'b1;
                  sram_we_n <= 1'b1;
                  host_ack  <= 1'b1;
               end else begin
                  phase_cnt <= phase_cnt - PH_W'(1);
               end
            end
            TURN: begin
               state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               sram_ce_n <= 1'b1;
               sram_oe_n <= 1'b1;
               sram_we_n <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_sram_arbiter.sv
// Bench for frame_sram_arbiter: scoreboarded reads/writes, priority vector
// table, and hand sequences for latency, starvation and reset mid-write.
module tb_frame_sram_arbiter;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 16;
   localparam int WR_CYC = 2;

   logic              tb_clk = 1'b0;
   logic              n_rst;
   logic              blank;
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic              disp_grant;
   logic              disp_rvalid;
   logic [DATA_W-1:0] disp_rdata;
   logic              host_req;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_ack;
   logic              host_starved;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;
   logic              sram_ce_n;
   logic              sram_oe_n;
   logic              sram_we_n;

   logic              rdata_override;
   logic [DATA_W-1:0] override_val;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0]        read_q[$];
   logic [ADDR_W+DATA_W-1:0] write_q[$];
   int grant_cnt  = 0;
   int rvalid_cnt = 0;
   int ack_cnt    = 0;
   int violations = 0;
   int first_evt  = 0;
   int we_len     = 0;
   logic              prev_we_low = 1'b0;
   logic [ADDR_W-1:0] cap_addr = '0;
   logic [DATA_W-1:0] cap_data = '0;

   typedef struct {
      logic              rd;
      logic              wr;
      logic              blank;
      logic [ADDR_W-1:0] rd_addr;
      logic [ADDR_W-1:0] wr_addr;
      logic [DATA_W-1:0] wdata;
      int                exp_first;
   } vec_t;

   vec_t vecs[6];

   frame_sram_arbiter dut (
      .clk         (tb_clk),
      .n_rst       (n_rst),
      .blank       (blank),
      .disp_req    (disp_req),
      .disp_addr   (disp_addr),
      .disp_grant  (disp_grant),
      .disp_rvalid (disp_rvalid),
      .disp_rdata  (disp_rdata),
      .host_req    (host_req),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_ack    (host_ack),
      .host_starved(host_starved),
      .sram_addr   (sram_addr),
      .sram_wdata  (sram_wdata),
      .sram_rdata  (sram_rdata),
      .sram_ce_n   (sram_ce_n),
      .sram_oe_n   (sram_oe_n),
      .sram_we_n   (sram_we_n)
   );

   always #5 tb_clk = ~tb_clk;

   function automatic logic [DATA_W-1:0] sram_model(input logic [ADDR_W-1:0] a);
      return a[15:0] ^ 16'h5A5A ^ {13'd0, a[18:16]};
   endfunction

   assign sram_rdata = sram_oe_n ? '0 : (rdata_override ? override_val : sram_model(sram_addr));

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic wait_cycle();
      @(posedge tb_clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on rvalid/ack and watches bus protocol
   always @(negedge tb_clk) begin
      logic [ADDR_W+DATA_W-1:0] exp_wr;
      if (!n_rst) begin
         we_len      = 0;
         prev_we_low = 1'b0;
      end else begin
         if (!sram_oe_n && !sram_we_n) violations++;
         if (!sram_we_n) begin
            if (prev_we_low && ((sram_addr !== cap_addr) || (sram_wdata !== cap_data)))
               violations++;
            cap_addr    = sram_addr;
            cap_data    = sram_wdata;
            we_len++;
            prev_we_low = 1'b1;
            if (first_evt == 0) first_evt = 2;
         end else begin
            prev_we_low = 1'b0;
         end
         if (disp_grant) begin
            grant_cnt++;
            if (first_evt == 0) first_evt = 1;
         end
         if (disp_rvalid) begin
            rvalid_cnt++;
            if (read_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_rvalid: got rdata 0x%0h, no read pending", disp_rdata);
            end else begin
               check_output("read_data", 32'(disp_rdata), 32'(read_q.pop_front()));
            end
         end
         if (host_ack) begin
            ack_cnt++;
            if (write_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_ack: got ack, no write pending");
            end else begin
               exp_wr = write_q.pop_front();
               check_output("write_addr", 32'(cap_addr), 32'(exp_wr[ADDR_W+DATA_W-1:DATA_W]));
               check_output("write_data", 32'(cap_data), 32'(exp_wr[DATA_W-1:0]));
               check_output("we_low_cycles", 32'(we_len), 32'(WR_CYC));
            end
            we_len = 0;
         end
      end
   end

   task automatic apply_stimulus(input vec_t v, input int idx);
      int  rv0;
      int  a0;
      bit  done;
      rv0       = rvalid_cnt;
      a0        = ack_cnt;
      done      = 1'b0;
      first_evt = 0;
      blank     = v.blank;
      if (v.rd) begin
         disp_addr = v.rd_addr;
         disp_req  = 1'b1;
         read_q.push_back(sram_model(v.rd_addr));
      end
      if (v.wr) begin
         host_addr  = v.wr_addr;
         host_wdata = v.wdata;
         host_req   = 1'b1;
         write_q.push_back({v.wr_addr, v.wdata});
      end
      for (int i = 0; i < 40; i++) begin
         wait_cycle();
         if (disp_grant) disp_req = 1'b0;
         if (host_ack) host_req = 1'b0;
         if ((rvalid_cnt - rv0 == int'(v.rd)) && (ack_cnt - a0 == int'(v.wr))) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL vec%0d_timeout: got %0d rvalid %0d ack, expected %0d %0d",
                  idx, rvalid_cnt - rv0, ack_cnt - a0, v.rd, v.wr);
         disp_req = 1'b0;
         host_req = 1'b0;
      end
      check_output($sformatf("vec%0d_first_op", idx), 32'(first_evt), 32'(v.exp_first));
      repeat (2) wait_cycle();
   endtask

   initial begin
      int  starved_at;
      int  g0;
      int  r0;
      int  a0;
      int  win_grants;
      bit  got_write;
      bit  got_ack;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 19'h00000, 19'h00000, 16'h0000, 1};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 19'h00000, 19'h7FFFF, 16'hFFFF, 2};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 19'h3ABCD, 19'h01234, 16'h1357, 1};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 19'h40000, 19'h05555, 16'hC3C3, 2};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 19'h7FFFF, 19'h00000, 16'h0000, 1};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 19'h12121, 19'h6DEAD, 16'hBEAD, 2};

      n_rst          = 1'b0;
      blank          = 1'b0;
      disp_req       = 1'b0;
      disp_addr      = '0;
      host_req       = 1'b0;
      host_addr      = '0;
      host_wdata     = '0;
      rdata_override = 1'b0;
      override_val   = '0;

      // Reset values
      repeat (3) wait_cycle();
      check_output("rst_ce_n", 32'(sram_ce_n), 32'd1);
      check_output("rst_oe_n", 32'(sram_oe_n), 32'd1);
      check_output("rst_we_n", 32'(sram_we_n), 32'd1);
      check_output("rst_sram_addr", 32'(sram_addr), 32'd0);
      check_output("rst_disp_rdata", 32'(disp_rdata), 32'd0);
      check_output("rst_flags", 32'({disp_grant, disp_rvalid, host_ack, host_starved}), 32'd0);
      n_rst = 1'b1;
      repeat (2) wait_cycle();

      // Read latency with a fixed SRAM word
      $display("[TB] read latency sequence");
      rdata_override = 1'b1;
      override_val   = 16'hBEEF;
      read_q.push_back(16'hBEEF);
      disp_addr = 19'h12345;
      disp_req  = 1'b1;
      wait_cycle();
      check_output("rd_grant_c1", 32'(disp_grant), 32'd1);
      check_output("rd_addr_c1", 32'(sram_addr), 32'h12345);
      check_output("rd_strobes_c1", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'b001);
      disp_req = 1'b0;
      wait_cycle();
      check_output("rd_c2", 32'({disp_grant, disp_rvalid, sram_oe_n}), 32'b000);
      wait_cycle();
      check_output("rd_c3", 32'({disp_grant, disp_rvalid, sram_oe_n}), 32'b000);
      wait_cycle();
      check_output("rd_rvalid_c4", 32'(disp_rvalid), 32'd1);
      check_output("rd_rdata_c4", 32'(disp_rdata), 32'hBEEF);
      check_output("rd_oe_n_c4", 32'(sram_oe_n), 32'd1);
      wait_cycle();
      check_output("rd_rvalid_c5", 32'(disp_rvalid), 32'd0);
      rdata_override = 1'b0;
      repeat (2) wait_cycle();

      // Write, then hold host_req past the ack for a second write
      $display("[TB] write sequence");
      blank      = 1'b0;
      host_addr  = 19'h00010;
      host_wdata = 16'hA5A5;
      host_req   = 1'b1;
      write_q.push_back({19'h00010, 16'hA5A5});
      wait_cycle();
      check_output("wr_strobes_c1", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'b010);
      check_output("wr_addr_c1", 32'(sram_addr), 32'h00010);
      check_output("wr_data_c1", 32'(sram_wdata), 32'hA5A5);
      check_output("wr_ack_c1", 32'(host_ack), 32'd0);
      wait_cycle();
      check_output("wr_strobes_c2", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'b010);
      wait_cycle();
      check_output("wr_turn_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'b111);
      check_output("wr_turn_ack", 32'(host_ack), 32'd1);
      host_addr  = 19'h7FFFF;
      host_wdata = 16'h0F0F;
      write_q.push_back({19'h7FFFF, 16'h0F0F});
      wait_cycle();
      check_output("wr_idle_c4", 32'({host_ack, sram_we_n}), 32'b01);
      wait_cycle();
      check_output("wr2_we_n_c5", 32'(sram_we_n), 32'd0);
      check_output("wr2_addr_c5", 32'(sram_addr), 32'h7FFFF);
      got_ack = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (host_ack) begin
            got_ack = 1'b1;
            break;
         end
         wait_cycle();
      end
      check_output("wr2_ack_seen", 32'(got_ack), 32'd1);
      host_req = 1'b0;
      repeat (2) wait_cycle();

      // Priority vector table
      $display("[TB] priority vector table");
      for (int i = 0; i < 6; i++) apply_stimulus(vecs[i], i);

      // Starvation with the display hammering continuously
      $display("[TB] starvation sequence");
      blank      = 1'b0;
      disp_addr  = 19'h00ABC;
      disp_req   = 1'b1;
      host_addr  = 19'h22222;
      host_wdata = 16'h5555;
      host_req   = 1'b1;
      write_q.push_back({19'h22222, 16'h5555});
      starved_at = -1;
      for (int i = 1; i <= 1100; i++) begin
         wait_cycle();
         if (disp_grant) read_q.push_back(sram_model(disp_addr));
         if (host_starved) begin
            starved_at = i;
            break;
         end
      end
      check_output("starve_cycle", 32'(starved_at), 32'd1024);
      win_grants = 0;
      got_write  = 1'b0;
      for (int i = 0; i < 12; i++) begin
         wait_cycle();
         if (disp_grant) begin
            win_grants++;
            read_q.push_back(sram_model(disp_addr));
         end
         if (!sram_we_n) begin
            got_write = 1'b1;
            break;
         end
      end
      check_output("starve_write_granted", 32'(got_write), 32'd1);
      check_output("starve_no_read_first", 32'(win_grants), 32'd0);
      got_ack = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wait_cycle();
         if (disp_grant) read_q.push_back(sram_model(disp_addr));
         if (host_ack) begin
            got_ack = 1'b1;
            break;
         end
      end
      check_output("starve_ack_seen", 32'(got_ack), 32'd1);
      host_req = 1'b0;
      wait_cycle();
      if (disp_grant) read_q.push_back(sram_model(disp_addr));
      check_output("starve_cleared", 32'(host_starved), 32'd0);
      for (int i = 0; i < 10 && disp_req; i++) begin
         if (disp_grant) begin
            disp_req = 1'b0;
         end else begin
            wait_cycle();
            if (disp_grant) read_q.push_back(sram_model(disp_addr));
         end
      end
      disp_req = 1'b0;
      repeat (8) wait_cycle();

      // Back-to-back reads with random host traffic and blanking
      $display("[TB] back-to-back read sequence");
      g0        = grant_cnt;
      r0        = rvalid_cnt;
      disp_addr = 19'($urandom);
      disp_req  = 1'b1;
      for (int i = 0; i < 500; i++) begin
         wait_cycle();
         if (disp_grant) begin
            read_q.push_back(sram_model(disp_addr));
            disp_addr = 19'($urandom);
         end
         if (host_ack) begin
            host_req = 1'b0;
         end else if (!host_req && ($urandom_range(0, 15) == 0)) begin
            host_addr  = 19'($urandom);
            host_wdata = 16'($urandom);
            host_req   = 1'b1;
            write_q.push_back({host_addr, host_wdata});
         end
         blank = ($urandom_range(0, 7) == 0);
      end
      for (int i = 0; i < 60; i++) begin
         if (!disp_req && !host_req && read_q.size() == 0 && write_q.size() == 0) break;
         wait_cycle();
         if (disp_grant) begin
            read_q.push_back(sram_model(disp_addr));
            disp_req = 1'b0;
         end
         if (host_ack) host_req = 1'b0;
      end
      disp_req = 1'b0;
      host_req = 1'b0;
      blank    = 1'b0;
      check_output("b2b_rvalid_eq_grant", 32'(rvalid_cnt - r0), 32'(grant_cnt - g0));
      check_output("b2b_read_q_empty", 32'(read_q.size()), 32'd0);
      check_output("b2b_write_q_empty", 32'(write_q.size()), 32'd0);
      repeat (3) wait_cycle();

      // Reset while WE is low
      $display("[TB] reset mid-write sequence");
      host_addr  = 19'h33333;
      host_wdata = 16'h1234;
      host_req   = 1'b1;
      write_q.push_back({19'h33333, 16'h1234});
      wait_cycle();
      check_output("rstwr_we_n_low", 32'(sram_we_n), 32'd0);
      a0    = ack_cnt;
      n_rst = 1'b0;
      #1;
      check_output("rstwr_strobes_async", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'b111);
      host_req = 1'b0;
      write_q.delete();
      repeat (2) wait_cycle();
      n_rst = 1'b1;
      repeat (6) wait_cycle();
      check_output("rstwr_no_ack", 32'(ack_cnt - a0), 32'd0);
      check_output("rstwr_idle_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'b111);

      check_output("oe_we_exclusive", 32'(violations), 32'd0);
      check_output("final_read_q_empty", 32'(read_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
